// File: rtl/simple_serial_pkg.sv
// simple_serial_pkg: shared state encoding and line levels for the simple serial link
package simple_serial_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
endpackage

// File: rtl/simple_serial_bit_timer.sv
// simple_serial_bit_timer: counts CLKS_PER_BIT cycles per line bit and pulses bit_done on the last one
module simple_serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic bit_done
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    logic [TW-1:0] cnt;
    assign bit_done = enable && (cnt == TW'(CLKS_PER_BIT - 1));
    always_ff @(posedge clk) begin
        if (!rst_n || !enable || bit_done)
            cnt <= '0;
        else
            cnt <= cnt + TW'(1);
    end
endmodule

// File: rtl/simple_serial_tx.sv
// simple_serial_tx: valid/ready word in, start + LSB-first data + stop frame out on a registered line
module simple_serial_tx
    import simple_serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
    tx_state_t             state, state_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic [IW-1:0]         bit_idx, idx_n;
    logic                  serial_n;
    logic                  bit_done;
    simple_serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state != IDLE),
        .bit_done(bit_done)
    );
    assign tx_ready = (state == IDLE);
    assign tx_busy  = !tx_ready;
    // The line level is computed one cycle ahead so tx_serial comes straight from a flop.
    always_comb begin
        state_n  = state;
        shift_n  = shift_reg;
        idx_n    = bit_idx;
        serial_n = tx_serial;
        case (state)
            IDLE: if (tx_valid) begin
                state_n  = START;
                shift_n  = tx_data;
                idx_n    = '0;
                serial_n = LINE_START;
            end
            START: if (bit_done) begin
                state_n  = DATA;
                serial_n = shift_reg[0];
            end
            DATA: if (bit_done) begin
                if (bit_idx == LAST_IDX) begin
                    state_n  = STOP;
                    serial_n = LINE_IDLE;
                end else begin
                    shift_n  = shift_reg >> 1;
                    idx_n    = bit_idx + IW'(1);
                    serial_n = shift_n[0];
                end
            end
            STOP: if (bit_done) begin
                state_n  = IDLE;
                serial_n = LINE_IDLE;
            end
            default: begin
                state_n  = IDLE;
                serial_n = LINE_IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx_serial <= LINE_IDLE;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_idx   <= idx_n;
            tx_serial <= serial_n;
        end
    end
endmodule

// File: tb/tb_simple_serial_tx.sv
// tb_simple_serial_tx: directed frame checks on a 4-clock/bit and a 1-clock/bit transmitter
module tb_simple_serial_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data0 = '0, tx_data1 = '0;
    logic       tx_valid0 = 1'b0, tx_valid1 = 1'b0;
    logic       ready0, serial0, busy0, ready1, serial1, busy1;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    simple_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(ready0), .tx_serial(serial0), .tx_busy(busy0)
    );
    simple_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(ready1), .tx_serial(serial1), .tx_busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input bit sel, input string nm);
        logic s, r, b;
        s = sel ? serial1 : serial0;
        r = sel ? ready1 : ready0;
        b = sel ? busy1 : busy0;
        tests++;
        if (s !== 1'b1 || r !== 1'b1 || b !== 1'b0) begin
            fails++;
            $display("FAIL %s: serial=%b ready=%b busy=%b, want serial=1 ready=1 busy=0", nm, s, r, b);
        end
    endtask

    // Called just after the accept edge; walks the whole frame then checks the idle cycle after it.
    task automatic check_frame(input logic [7:0] d, input int cpb, input bit sel, input int disturb, input string nm);
        logic [9:0] f;
        logic s, r, b;
        f = {1'b1, d, 1'b0};
        for (int i = 0; i < 10 * cpb; i++) begin
            s = sel ? serial1 : serial0;
            r = sel ? ready1 : ready0;
            b = sel ? busy1 : busy0;
            tests++;
            if (s !== f[i / cpb] || r !== 1'b0 || b !== 1'b1) begin
                fails++;
                $display("FAIL %s cycle %0d: serial=%b ready=%b busy=%b, want serial=%b ready=0 busy=1",
                         nm, i, s, r, b, f[i / cpb]);
            end
            if (disturb >= 0 && i == disturb) begin
                tx_data0  = 8'h3C;
                tx_valid0 = 1'b1;
            end else if (disturb >= 0 && i == disturb + 1) begin
                tx_valid0 = 1'b0;
            end
            step();
        end
        check_idle(sel, {nm, "_end"});
    endtask

    task automatic send(input logic [7:0] d, input bit sel);
        if (sel) begin
            tx_data1  = d;
            tx_valid1 = 1'b1;
        end else begin
            tx_data0  = d;
            tx_valid0 = 1'b1;
        end
        step();
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_idle(1'b0, "reset0");
            check_idle(1'b1, "reset1");
            step();
        end
    endtask

    task automatic test_single_frame();
        send(8'hA5, 1'b0);
        check_frame(8'hA5, 4, 1'b0, -1, "frame_a5");
    endtask

    task automatic test_back_to_back();
        tx_data0  = 8'h00;
        tx_valid0 = 1'b1;
        step();
        tx_data0 = 8'hFF;
        check_frame(8'h00, 4, 1'b0, -1, "b2b_00");
        step();
        tx_valid0 = 1'b0;
        check_frame(8'hFF, 4, 1'b0, -1, "b2b_ff");
    endtask

    task automatic test_ignored_while_busy();
        send(8'hA5, 1'b0);
        check_frame(8'hA5, 4, 1'b0, 15, "busy_ignore");
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle(1'b0, "no_second_frame");
        end
    endtask

    task automatic test_reset_mid_frame();
        send(8'h81, 1'b0);
        repeat (15) step();
        tests++;
        if (busy0 !== 1'b1) begin
            fails++;
            $display("FAIL mid_frame_busy: busy=%b, want 1", busy0);
        end
        rst_n = 1'b0;
        step();
        check_idle(1'b0, "mid_reset");
        rst_n = 1'b1;
        step();
        check_idle(1'b0, "after_reset");
        send(8'h81, 1'b0);
        check_frame(8'h81, 4, 1'b0, -1, "frame_81");
        rst_n     = 1'b0;
        tx_data0  = 8'hFF;
        tx_valid0 = 1'b1;
        step();
        check_idle(1'b0, "reset_vs_accept");
        rst_n     = 1'b1;
        tx_valid0 = 1'b0;
        step();
        check_idle(1'b0, "nothing_latched");
    endtask

    task automatic test_min_timing();
        send(8'h5A, 1'b1);
        check_frame(8'h5A, 1, 1'b1, -1, "frame_5a_cpb1");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_while_busy();
        test_reset_mid_frame();
        test_min_timing();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
